sdf_stage_ctrl: RTL and testbench
=================================

// Module: sdf_stage_ctrl
// PURPOSE
//  Sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage.
//  Drives the stage's delay-line buffer, butterfly/bypass select and twiddle ROM address from the sample valid stream.
//  Per frame of 2*delay_length samples: fill the buffer, run the butterfly, then drain the buffered lower outputs.
//  Draining overlaps with filling of the next frame.
// PARAMETERS
//  delay_length  8  delay-line depth in samples; power of two, >= 2; frame = 2*delay_length samples
//  tw_stride     1  twiddle ROM address increment per drained sample
//  addr_width    4  width of tw_addr; address arithmetic is modulo 2**addr_width
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  en          in   1           global stall; 0 freezes all state
//  in_valid    in   1           input sample valid
//  buf_en      out  1           delay-line shift enable (comb)
//  bf_sel      out  1           0 = bypass/fill, 1 = butterfly (comb, from state)
//  tw_valid    out  1           twiddle multiply active on buffer output (comb)
//  tw_addr     out  addr_width  twiddle ROM address = drain_cnt*tw_stride (comb)
//  out_valid   out  1           stage output sample valid (comb)
//  frame_done  out  1           registered 1-cycle pulse after last COMPUTE accept
//  busy        out  1           state != IDLE (comb)
// BEHAVIOUR
//  - Reset (sync): state=IDLE, fill_cnt=0, drain_cnt=0, frame_done=0; all comb outputs forced 0 while reset=1.
//  - accept = en & in_valid. Nothing advances when en=0; buf_en, out_valid and tw_valid are 0; frame_done still clears.
//  - Counters: fill_cnt is 0..delay_length, incremented per accept. drain_cnt is 0..delay_length-1, incremented per en cycle in DRAIN.
//  - IDLE: bf_sel=0. accept -> FILL, fill_cnt=1.
//  - FILL: bf_sel=0, buf_en=accept, out_valid=0.
//    accept with fill_cnt==delay_length-1 -> COMPUTE, fill_cnt=0; otherwise fill_cnt++.
//  - COMPUTE: bf_sel=1, buf_en=accept, out_valid=accept.
//    accept with fill_cnt==delay_length-1 -> DRAIN, fill_cnt=0, drain_cnt=0, frame_done=1 next cycle; otherwise fill_cnt++.
//  - DRAIN: bf_sel=0, buf_en=en regardless of in_valid, out_valid=en, tw_valid=en.
//    - Each en cycle: drain_cnt++. An accept in the same cycle counts as a next-frame sample: fill_cnt++.
//    - On the en cycle with drain_cnt==delay_length-1, using the post-increment fill_cnt:
//      ==delay_length -> COMPUTE with fill_cnt=0; >0 -> FILL keeping fill_cnt; ==0 -> IDLE.
//  - Fill can never overtake drain (both advance at most 1 per en cycle). A continuous stream gives zero-bubble back-to-back frames.
//  - Latency: all outputs except frame_done are combinational from state and inputs; state updates on the next clk edge.
//  - Reset mid-frame discards the frame; no partial frame_done is generated.
// TESTING (delay_length=8, tw_stride=1, addr_width=4)
//  1. Reset, then 16 consecutive valid samples, then in_valid=0:
//     -> bf_sel=0 for samples 0-7 and 1 for 8-15; out_valid on 8-15.
//     -> frame_done high the cycle after sample 15; 8 DRAIN cycles with tw_addr 0..7 and tw_valid=1; then IDLE, busy=0.
//  2. 32 continuous samples -> samples 16-23 accepted during DRAIN; DRAIN exits straight to COMPUTE;
//     out_valid unbroken for 24 cycles; two frame_done pulses 16 cycles apart.
//  3. in_valid toggling 1/0 for one frame -> counters advance only on accepts; COMPUTE entered after the 8th accept, not the 8th cycle.
//  4. New frame starts at drain_cnt=3 (5 accepts during DRAIN) -> exits to FILL with fill_cnt=5; COMPUTE after 3 more accepts.
//  5. en=0 for 4 cycles mid-COMPUTE and mid-DRAIN -> state, counters and tw_addr hold; buf_en=out_valid=tw_valid=0; resume exactly where stopped.
//  6. reset asserted mid-COMPUTE (fill_cnt=5) -> next cycle IDLE, counters 0, no frame_done; the following 16-sample frame behaves as in test 1.

Source files
------------

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: delay-line enable,
// butterfly select and twiddle addressing driven by the sample stream.
module sdf_stage_ctrl #(
    parameter int delay_length = 8,
    parameter int tw_stride    = 1,
    parameter int addr_width   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  buf_en,
    output logic                  bf_sel,
    output logic                  tw_valid,
    output logic [addr_width-1:0] tw_addr,
    output logic                  out_valid,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int dw = (delay_length > 1) ? $clog2(delay_length) : 1;
    localparam int fw = dw + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMPUTE,
        DRAIN
    } state_t;

    state_t        state;
    logic [fw-1:0] fill_cnt;
    logic [fw-1:0] fill_inc;
    logic [dw-1:0] drain_cnt;
    logic          accept;
    logic          fill_last;
    logic          drain_last;

    assign accept     = en & in_valid;
    assign fill_inc   = fill_cnt + fw'(accept);
    assign fill_last  = (fill_cnt == fw'(delay_length - 1));
    assign drain_last = (drain_cnt == dw'(delay_length - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            drain_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            state    <= FILL;
                            fill_cnt <= fw'(1);
                        end
                    end
                    FILL: begin
                        if (accept) begin
                            if (fill_last) begin
                                state    <= COMPUTE;
                                fill_cnt <= '0;
                            end else begin
                                fill_cnt <= fill_inc;
                            end
                        end
                    end
                    COMPUTE: begin
                        if (accept) begin
                            if (fill_last) begin
                                state      <= DRAIN;
                                fill_cnt   <= '0;
                                drain_cnt  <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                fill_cnt <= fill_inc;
                            end
                        end
                    end
                    DRAIN: begin
                        // Samples arriving now belong to the next frame.
                        drain_cnt <= drain_cnt + dw'(1);
                        fill_cnt  <= fill_inc;
                        if (drain_last) begin
                            drain_cnt <= '0;
                            if (fill_inc == fw'(delay_length)) begin
                                state    <= COMPUTE;
                                fill_cnt <= '0;
                            end else if (fill_inc != '0) begin
                                state <= FILL;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        buf_en    = 1'b0;
        bf_sel    = 1'b0;
        tw_valid  = 1'b0;
        tw_addr   = '0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            busy    = (state != IDLE);
            tw_addr = addr_width'(drain_cnt) * addr_width'(tw_stride);
            unique case (state)
                IDLE: buf_en = accept;
                FILL: buf_en = accept;
                COMPUTE: begin
                    bf_sel    = 1'b1;
                    buf_en    = accept;
                    out_valid = accept;
                end
                DRAIN: begin
                    buf_en    = en;
                    out_valid = en;
                    tw_valid  = en;
                end
                default: buf_en = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: per-cycle scoreboard against a reference
// model plus hand-derived scenario checks (delay_length=8).
module tb_sdf_stage_ctrl;
    localparam int DL = 8;

    logic       clk;
    logic       reset;
    logic       en;
    logic       in_valid;
    logic       buf_en;
    logic       bf_sel;
    logic       tw_valid;
    logic [3:0] tw_addr;
    logic       out_valid;
    logic       frame_done;
    logic       busy;

    typedef struct packed {
        logic       buf_en;
        logic       bf_sel;
        logic       tw_valid;
        logic [3:0] tw_addr;
        logic       out_valid;
        logic       frame_done;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs;
    obs_t expv;
    int   checks = 0;
    int   errors = 0;
    int   m_st;
    int   m_fill;
    int   m_drain;
    logic m_fd;

    sdf_stage_ctrl #(
        .delay_length(DL),
        .tw_stride(1),
        .addr_width(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .in_valid(in_valid),
        .buf_en(buf_en),
        .bf_sel(bf_sel),
        .tw_valid(tw_valid),
        .tw_addr(tw_addr),
        .out_valid(out_valid),
        .frame_done(frame_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        return {buf_en, bf_sel, tw_valid, tw_addr,
                out_valid, frame_done, busy};
    endfunction

    // Drive one cycle, push the model's prediction, advance the model.
    task automatic drive(input logic r, input logic e, input logic v);
        logic acc;
        obs_t x;
        int   nf;
        @(negedge clk);
        reset    = r;
        en       = e;
        in_valid = v;
        #1;
        acc = e & v;
        x = '0;
        x.frame_done = m_fd;
        if (!r) begin
            x.busy      = (m_st != 0);
            x.bf_sel    = (m_st == 2);
            x.tw_addr   = 4'(m_drain);
            x.buf_en    = (m_st == 3) ? e : acc;
            x.out_valid = (m_st == 2 && acc) || (m_st == 3 && e);
            x.tw_valid  = (m_st == 3) && e;
        end
        exp_q.push_back(x);
        m_fd = 1'b0;
        if (r) begin
            m_st = 0; m_fill = 0; m_drain = 0;
        end else if (e) begin
            case (m_st)
                0: if (acc) begin m_st = 1; m_fill = 1; end
                1: if (acc) begin
                    if (m_fill == DL - 1) begin m_st = 2; m_fill = 0; end
                    else m_fill++;
                end
                2: if (acc) begin
                    if (m_fill == DL - 1) begin
                        m_st = 3; m_fill = 0; m_drain = 0; m_fd = 1'b1;
                    end else m_fill++;
                end
                3: begin
                    nf = m_fill + int'(acc);
                    if (m_drain == DL - 1) begin
                        m_drain = 0;
                        if (nf == DL) begin m_st = 2; m_fill = 0; end
                        else begin m_fill = nf; m_st = (nf > 0) ? 1 : 0; end
                    end else begin
                        m_drain++; m_fill = nf;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        obs = sample();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, 10'b0);
        end
        m_st = 0; m_fill = 0; m_drain = 0; m_fd = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        obs = sample(); expv = exp_q.pop_front(); checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_forced got=%b exp=%b", obs, expv);
        end
    endtask

    task automatic test_single_frame(input string name);
        int n_ov = 0;
        int fd_cyc = -1;
        for (int i = 0; i < 28; i++) begin
            drive(1'b0, 1'b1, i < 16);
            obs = sample(); expv = exp_q.pop_front(); checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s cyc %0d got=%b exp=%b", name, i, obs, expv);
            end
            if (obs.out_valid === 1'b1) n_ov++;
            if (obs.frame_done === 1'b1 && fd_cyc < 0) fd_cyc = i;
            if (i < 16 && obs.bf_sel !== (i >= 8)) begin
                errors++;
                $display("FAIL %s bf_sel smp %0d got=%b exp=%b",
                         name, i, obs.bf_sel, i >= 8);
            end
            if (i >= 16 && i < 24) begin
                checks++;
                if (obs.tw_addr !== 4'(i - 16) || obs.tw_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s drain cyc %0d got=%h/%b exp=%h/1",
                             name, i, obs.tw_addr, obs.tw_valid, 4'(i - 16));
                end
            end
        end
        checks++;
        if (n_ov != 16) begin
            errors++;
            $display("FAIL %s ov_count got=%0d exp=16", name, n_ov);
        end
        checks++;
        if (fd_cyc != 16) begin
            errors++;
            $display("FAIL %s fd_cycle got=%0d exp=16", name, fd_cyc);
        end
        checks++;
        if (obs.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_busy got=%b exp=0", name, obs.busy);
        end
    endtask

    task automatic test_back_to_back();
        int fd[$];
        int gap = 0;
        for (int i = 0; i < 44; i++) begin
            drive(1'b0, 1'b1, i < 32);
            obs = sample(); expv = exp_q.pop_front(); checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL b2b cyc %0d got=%b exp=%b", i, obs, expv);
            end
            if (obs.frame_done === 1'b1) fd.push_back(i);
            if (i >= 8 && i < 32 && obs.out_valid !== 1'b1) gap++;
        end
        checks++;
        if (gap != 0) begin
            errors++;
            $display("FAIL b2b ov_gaps got=%0d exp=0", gap);
        end
        checks++;
        if (fd.size() != 2 || fd[0] != 16 || fd[1] != 32) begin
            errors++;
            $display("FAIL b2b fd got=%0d pulses exp=2 at 16,32", fd.size());
        end
    endtask

    task automatic test_toggle();
        int first_bf = -1;
        for (int i = 0; i < 44; i++) begin
            drive(1'b0, 1'b1, (i < 32) && (i % 2 == 0));
            obs = sample(); expv = exp_q.pop_front(); checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL toggle cyc %0d got=%b exp=%b", i, obs, expv);
            end
            if (obs.bf_sel === 1'b1 && first_bf < 0) first_bf = i;
        end
        checks++;
        if (first_bf != 15) begin
            errors++;
            $display("FAIL toggle compute_start got=%0d exp=15", first_bf);
        end
    endtask

    task automatic test_overlap();
        int rise = -1;
        int fd2 = -1;
        for (int i = 0; i < 48; i++) begin
            drive(1'b0, 1'b1, (i < 16) || (i >= 19 && i < 35));
            obs = sample(); expv = exp_q.pop_front(); checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL overlap cyc %0d got=%b exp=%b", i, obs, expv);
            end
            if (i == 24) begin
                checks++;
                if (obs.busy !== 1'b1 || obs.bf_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap fill got=%b%b exp=10",
                             obs.busy, obs.bf_sel);
                end
            end
            if (i > 16 && rise < 0 && obs.bf_sel === 1'b1) rise = i;
            if (i > 16 && obs.frame_done === 1'b1) fd2 = i;
        end
        checks++;
        if (rise != 27 || fd2 != 35) begin
            errors++;
            $display("FAIL overlap timing got=%0d/%0d exp=27/35", rise, fd2);
        end
    endtask

    task automatic test_stall();
        int   sent = 0;
        int   fd_cyc = -1;
        logic e;
        logic v;
        logic stall_bf;
        for (int i = 0; i < 36; i++) begin
            e = !((i >= 11 && i < 15) || (i >= 23 && i < 27));
            v = e ? (sent < 16) : 1'b1;
            if (e && v) sent++;
            drive(1'b0, e, v);
            obs = sample(); expv = exp_q.pop_front(); checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stall cyc %0d got=%b exp=%b", i, obs, expv);
            end
            if (obs.frame_done === 1'b1 && fd_cyc < 0) fd_cyc = i;
            if (!e) begin
                stall_bf = (i < 15);
                checks++;
                if ({obs.buf_en, obs.out_valid, obs.tw_valid} !== 3'b000 ||
                    obs.bf_sel !== stall_bf ||
                    obs.tw_addr !== (stall_bf ? 4'd0 : 4'd3) ||
                    obs.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall hold cyc %0d got=%b", i, obs);
                end
            end
        end
        checks++;
        if (fd_cyc != 20) begin
            errors++;
            $display("FAIL stall fd_cycle got=%0d exp=20", fd_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int fd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive(i == 13, 1'b1, i <= 13);
            obs = sample(); expv = exp_q.pop_front(); checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rst_mid cyc %0d got=%b exp=%b", i, obs, expv);
            end
            if (i == 12) begin
                checks++;
                if (obs.bf_sel !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid compute got=%b exp=1", obs.bf_sel);
                end
            end
            if (i == 14) begin
                checks++;
                if (obs.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid idle got=%b exp=0", obs.busy);
                end
            end
            if (i >= 13 && obs.frame_done === 1'b1) fd_seen++;
        end
        checks++;
        if (fd_seen != 0) begin
            errors++;
            $display("FAIL rst_mid frame_done got=%0d exp=0", fd_seen);
        end
        test_single_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_frame("single");
        test_back_to_back();
        test_toggle();
        test_overlap();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
